// File: rtl/sdram_pkg.sv
// Shared SDRAM controller types: address width, byte type and
// the channel-B prefetch FSM state encoding.
package sdram_pkg;

    localparam int SDRAM_AW = 21;

    typedef logic [7:0]          byte_t;
    typedef logic [SDRAM_AW-1:0] addr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE
    } bpf_state_e;

endpackage

// File: rtl/sdram_b_prefetch_if.sv
// Channel-B prefetch bundle: run control, controller channel B
// and the consumer-side FIFO read port.
interface sdram_b_prefetch_if #(
    parameter int LEN_W = 11,
    parameter int LVL_W = 5
);

    logic               start;
    sdram_pkg::addr_t   start_addr;
    logic [LEN_W-1:0]   length;
    logic               busy;
    logic               done;

    sdram_pkg::addr_t   RAM_B_ADDR;
    logic               RAM_B_REQ;
    sdram_pkg::byte_t   RAM_B_DO;

    logic               rd_en;
    sdram_pkg::byte_t   rd_data;
    logic               empty;
    logic [LVL_W-1:0]   level;

    modport master (
        input  start, start_addr, length, RAM_B_DO, rd_en,
        output busy, done, RAM_B_ADDR, RAM_B_REQ,
        output rd_data, empty, level
    );

    modport slave (
        output start, start_addr, length, RAM_B_DO, rd_en,
        input  busy, done, RAM_B_ADDR, RAM_B_REQ,
        input  rd_data, empty, level
    );

endinterface

// File: rtl/sdram_b_prefetch_fifo.sv
// Show-ahead synchronous FIFO with clear; power-of-two depth so
// the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q;
    logic [AW-1:0]    rp_q;
    logic [AW:0]      cnt_q;
    logic             do_pop;
    logic             do_push;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rp_q];
    assign level   = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && !clr && do_push) mem_q[wp_q] <= din;
    end

endmodule

// File: rtl/sdram_b_prefetch.sv
// Sequential read-ahead engine for SDRAM channel B: one toggle
// request per byte, fixed settle delay, results queued in a FIFO.
module sdram_b_prefetch #(
    parameter int FIFO_DEPTH = 16,
    parameter int B_LATENCY  = 16,
    parameter int LEN_W      = 11
) (
    input logic                clk,
    input logic                reset_n,
    sdram_b_prefetch_if.master bus
);

    import sdram_pkg::*;

    localparam int            LVW   = $clog2(FIFO_DEPTH) + 1;
    localparam int            WW    = $clog2(B_LATENCY);
    localparam logic [WW-1:0] WLOAD = WW'(B_LATENCY - 1);

    bpf_state_e       state_q;
    addr_t            addr_q;
    addr_t            ram_addr_q;
    logic             req_q;
    logic [LEN_W-1:0] rem_q;
    logic [WW-1:0]    wcnt_q;
    byte_t            data_q;
    logic             busy_q;
    logic             done_q;

    logic             fifo_push;
    logic             fifo_clr;
    logic             fifo_full;
    logic             fifo_empty;
    byte_t            fifo_dout;
    logic [LVW-1:0]   fifo_level;

    assign fifo_push = (state_q == S_STORE);
    assign fifo_clr  = bus.start && busy_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (fifo_clr),
        .push    (fifo_push),
        .din     (data_q),
        .pop     (bus.rd_en),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    // The wait counter runs free of the FSM so an aborted request
    // still blocks the next toggle until its slot has expired.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            ram_addr_q <= '0;
            req_q      <= 1'b0;
            rem_q      <= '0;
            wcnt_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wcnt_q != '0) wcnt_q <= wcnt_q - 1'b1;
            if (bus.start) begin
                addr_q <= bus.start_addr;
                rem_q  <= bus.length;
                if (bus.length == '0) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end else begin
                    busy_q  <= 1'b1;
                    state_q <= S_ISSUE;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_ISSUE: begin
                        if (wcnt_q == '0 && !fifo_full) begin
                            ram_addr_q <= addr_q;
                            req_q      <= ~req_q;
                            wcnt_q     <= WLOAD;
                            state_q    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (wcnt_q == '0) begin
                            data_q  <= bus.RAM_B_DO;
                            state_q <= S_STORE;
                        end
                    end
                    S_STORE: begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.RAM_B_ADDR = ram_addr_q;
    assign bus.RAM_B_REQ  = req_q;
    assign bus.rd_data    = fifo_dout;
    assign bus.empty      = fifo_empty;
    assign bus.level      = fifo_level;

endmodule

// File: tb/tb_sdram_b_prefetch.sv
// Bench for sdram_b_prefetch: channel-B model plus scoreboard of
// expected addresses and bytes.
module tb_sdram_b_prefetch;

    import sdram_pkg::*;

    localparam int BL    = 16;
    localparam int DEPTH = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    sdram_b_prefetch_if #(.LEN_W(11), .LVL_W(5)) bus();

    sdram_b_prefetch #(
        .FIFO_DEPTH (DEPTH),
        .B_LATENCY  (BL),
        .LEN_W      (11)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int    n_chk    = 0;
    int    n_pass   = 0;
    byte_t exp_data[$];
    addr_t exp_addr[$];
    int    tog_cnt  = 0;
    int    done_cnt = 0;
    int    cyc      = 0;
    int    prev_tog = 0;
    bit    have_prev = 1'b0;
    bit    consume  = 1'b0;
    logic  last_req = 1'b0;
    int    dly      = 0;
    byte_t pend     = 8'h00;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Channel-B model, consumer and output monitors.
    always @(negedge clk) begin
        cyc++;
        bus.rd_en = consume;
        if (!reset_n) begin
            last_req  = 1'b0;
            dly       = 0;
            have_prev = 1'b0;
        end else begin
            if (dly > 0) begin
                dly--;
                if (dly == 0) bus.RAM_B_DO = pend;
            end
            if (bus.RAM_B_REQ !== last_req) begin
                last_req = bus.RAM_B_REQ;
                tog_cnt++;
                if (have_prev)
                    check("tog_gap", 32'((cyc - prev_tog) >= BL), 32'd1);
                have_prev = 1'b1;
                prev_tog  = cyc;
                if (exp_addr.size() == 0)
                    check("tog_extra", 32'd1, 32'd0);
                else
                    check("tog_addr", 32'(bus.RAM_B_ADDR),
                          32'(exp_addr.pop_front()));
                pend        = bus.RAM_B_ADDR[7:0] ^ 8'h5A;
                bus.RAM_B_DO = ~pend;
                dly         = $urandom_range(2, BL - 1);
            end
            if (bus.done) begin
                done_cnt++;
                check("done_busy", 32'(bus.busy), 32'd0);
            end
            if (consume && !bus.empty) begin
                if (exp_data.size() == 0)
                    check("pop_extra", 32'd1, 32'd0);
                else
                    check("rd_data", 32'(bus.rd_data),
                          32'(exp_data.pop_front()));
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_run(addr_t a, int len);
        addr_t x;
        if (bus.busy) begin
            exp_data.delete();
            exp_addr.delete();
        end
        for (int i = 0; i < len; i++) begin
            x = a + 21'(i);
            exp_addr.push_back(x);
            exp_data.push_back(x[7:0] ^ 8'h5A);
        end
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.length     = 11'(len);
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(int d0, int budget);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            step();
            k++;
        end
        check("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_drain(int budget);
        int k = 0;
        while ((exp_data.size() != 0 || !bus.empty) && k < budget) begin
            step();
            k++;
        end
        check("drain_left", 32'(exp_data.size()), 32'd0);
        check("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int d0;
        int k;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;

        reset_n = 1'b0;
        step(3);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_addr", 32'(bus.RAM_B_ADDR), 32'd0);
        check("rst_req", 32'(bus.RAM_B_REQ), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        reset_n = 1'b1;
        step(2);

        // basic 4-byte run
        consume = 1'b1;
        t0 = tog_cnt;
        d0 = done_cnt;
        start_run(21'h00100, 4);
        wait_done(d0, 6 * (BL + 2));
        check("t1_busy", 32'(bus.busy), 32'd0);
        wait_drain(20);
        check("t1_togs", 32'(tog_cnt - t0), 32'd4);
        check("t1_dones", 32'(done_cnt - d0), 32'd1);

        // empty run
        t0 = tog_cnt;
        d0 = done_cnt;
        start_run(21'h01234, 0);
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_busy", 32'(bus.busy), 32'd0);
        step();
        check("t2_done_end", 32'(bus.done), 32'd0);
        step(5);
        check("t2_empty", 32'(bus.empty), 32'd1);
        check("t2_togs", 32'(tog_cnt - t0), 32'd0);
        check("t2_dones", 32'(done_cnt - d0), 32'd1);

        // address wrap
        t0 = tog_cnt;
        d0 = done_cnt;
        start_run(21'h1FFFFE, 3);
        wait_done(d0, 5 * (BL + 2));
        wait_drain(20);
        check("t3_togs", 32'(tog_cnt - t0), 32'd3);

        // FIFO fill and stall, then drain
        consume = 1'b0;
        t0 = tog_cnt;
        d0 = done_cnt;
        start_run(21'h00040, 40);
        step(DEPTH * (BL + 2) + 40);
        check("t4_stall_togs", 32'(tog_cnt - t0), 32'(DEPTH));
        check("t4_level", 32'(bus.level), 32'(DEPTH));
        check("t4_busy", 32'(bus.busy), 32'd1);
        consume = 1'b1;
        wait_done(d0, 30 * (BL + 2));
        wait_drain(40);
        check("t4_togs", 32'(tog_cnt - t0), 32'd40);

        // abort during WAIT of the second byte
        consume = 1'b0;
        t0 = tog_cnt;
        d0 = done_cnt;
        start_run(21'h00200, 5);
        k = 0;
        while (tog_cnt - t0 < 2 && k < 4 * (BL + 2)) begin
            step();
            k++;
        end
        step(3);
        check("t5_pre_level", 32'(bus.level), 32'd1);
        start_run(21'h00300, 2);
        check("t5_clr_level", 32'(bus.level), 32'd0);
        check("t5_clr_busy", 32'(bus.busy), 32'd1);
        consume = 1'b1;
        wait_done(d0, 5 * (BL + 2));
        wait_drain(20);
        check("t5_togs", 32'(tog_cnt - t0), 32'd4);
        check("t5_dones", 32'(done_cnt - d0), 32'd1);

        // reset during WAIT
        t0 = tog_cnt;
        start_run(21'h00400, 3);
        k = 0;
        while (tog_cnt == t0 && k < 2 * (BL + 2)) begin
            step();
            k++;
        end
        step(4);
        d0 = done_cnt;
        reset_n = 1'b0;
        step();
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_level", 32'(bus.level), 32'd0);
        check("t6_req", 32'(bus.RAM_B_REQ), 32'd0);
        reset_n = 1'b1;
        exp_data.delete();
        exp_addr.delete();
        t0 = tog_cnt;
        step(3 * BL);
        check("t6_req_hold", 32'(bus.RAM_B_REQ), 32'd0);
        check("t6_no_tog", 32'(tog_cnt - t0), 32'd0);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check("t6_empty", 32'(bus.empty), 32'd1);
        start_run(21'h00500, 2);
        wait_done(d0, 5 * (BL + 2));
        wait_drain(20);
        check("t6_togs", 32'(tog_cnt - t0), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
